twd1_seq: RTL and testbench

//  Sequences the 64-entry module-1 twiddle ROM (<2.7> signed, 9-bit) for a streaming 512-point radix-8 FFT stage.

---
 rtl/twd1_seq_if.sv | 29 ++
 rtl/twd1_seq.sv | 121 ++++++++++++
 tb/tb_twd1_seq.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/twd1_seq_if.sv
// Sample/twiddle stream bundle between the stage-0 butterfly, the twiddle sequencer and the multiplier.
// master drives samples in and takes results; slave is the sequencer.
interface twd1_seq_if #(
  parameter int DIN_W = 13,
  parameter int TW_W  = 9
);
  logic                    s_valid;
  logic                    s_ready;
  logic                    s_sof;
  logic signed [DIN_W-1:0] s_re;
  logic signed [DIN_W-1:0] s_im;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_last;
  logic signed [DIN_W-1:0] m_re;
  logic signed [DIN_W-1:0] m_im;
  logic signed [TW_W-1:0]  m_tw_re;
  logic signed [TW_W-1:0]  m_tw_im;

  modport master (
    output s_valid, s_sof, s_re, s_im, m_ready,
    input  s_ready, m_valid, m_last, m_re, m_im, m_tw_re, m_tw_im
  );

  modport slave (
    input  s_valid, s_sof, s_re, s_im, m_ready,
    output s_ready, m_valid, m_last, m_re, m_im, m_tw_re, m_tw_im
  );
endinterface

// File: rtl/twd1_seq.sv
// Module-1 twiddle ROM sequencer: tags samples with frame position, pairs each with its twiddle. Optional stats via TWD1_SEQ_STAT_EN.
// Latency 1 cycle accept->m_valid; s_ready = ~m_valid | m_ready, output held stable while stalled.
module twd1_seq #(
  parameter int DIN_W     = 13,
  parameter int TW_W      = 9,
  parameter int FRAME_LEN = 512,
  parameter int ROM_DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  twd1_seq_if.slave              bus,
  output logic [8:0]             rom_addr_out,
  input  logic signed [TW_W-1:0] rom_re_in,
  input  logic signed [TW_W-1:0] rom_im_in,
  output logic                   sync_err
`ifdef TWD1_SEQ_STAT_EN
  ,
  output logic [15:0]            frame_cnt,
  output logic [7:0]             err_cnt,
  output logic [7:0]             drop_cnt
`endif
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int AW    = $clog2(ROM_DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    vld_q;
  logic                    last_q;
  logic signed [DIN_W-1:0] re_q;
  logic signed [DIN_W-1:0] im_q;
  logic signed [TW_W-1:0]  tw_re_q;
  logic signed [TW_W-1:0]  tw_im_q;

  logic           ready;
  logic           accept;
  logic           sof_acc;
  logic           drop;
  logic [AW-1:0]  idx;

  assign ready   = ~vld_q | bus.m_ready;
  assign accept  = bus.s_valid & ready;
  assign sof_acc = accept & bus.s_sof;
  assign drop    = accept & ~bus.s_sof & (state == IDLE);
  // A start-of-frame sample always reads entry 0, even when it interrupts a frame.
  assign idx          = sof_acc ? '0 : cnt[AW-1:0];
  assign rom_addr_out = 9'(idx);

  assign bus.s_ready = ready;
  assign bus.m_valid = vld_q;
  assign bus.m_last  = last_q;
  assign bus.m_re    = re_q;
  assign bus.m_im    = im_q;
  assign bus.m_tw_re = tw_re_q;
  assign bus.m_tw_im = tw_im_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
      tw_re_q  <= '0;
      tw_im_q  <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (vld_q && bus.m_ready) begin
        vld_q <= 1'b0;
      end
      if (accept && !drop) begin
        vld_q   <= 1'b1;
        re_q    <= bus.s_re;
        im_q    <= bus.s_im;
        tw_re_q <= rom_re_in;
        tw_im_q <= rom_im_in;
        if (bus.s_sof) begin
          // Mid-frame sof truncates the running frame: no m_last for it.
          state    <= RUN;
          cnt      <= CNT_W'(1);
          last_q   <= 1'b0;
          sync_err <= (cnt != '0);
        end else if (cnt == LAST_IDX) begin
          state  <= IDLE;
          cnt    <= '0;
          last_q <= 1'b1;
        end else begin
          cnt    <= cnt + CNT_W'(1);
          last_q <= 1'b0;
        end
      end
    end
  end

`ifdef TWD1_SEQ_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (vld_q && bus.m_ready && last_q && (frame_cnt != '1)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (sof_acc && (cnt != '0) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_twd1_seq.sv
// Directed bench for twd1_seq: frame sequencing, twiddle alignment, backpressure, resync and reset.
module tb_twd1_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  twd1_seq_if #(.DIN_W(13), .TW_W(9)) bus ();

  logic [8:0]        rom_addr;
  logic signed [8:0] rom_re;
  logic signed [8:0] rom_im;
  logic              sync_err;
`ifdef TWD1_SEQ_STAT_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic [7:0]  drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int sn = 0;

  // ROM model: the entries the bench pins by value, distinct filler elsewhere.
  function automatic logic signed [8:0] rom_re_f(input int a);
    case (a)
      0:       return 9'sd128;
      9:       return 9'sd118;
      12:      return 9'sd0;
      63:      return 9'sd13;
      default: return 9'(3 * a - 100);
    endcase
  endfunction

  function automatic logic signed [8:0] rom_im_f(input int a);
    case (a)
      0:       return 9'sd0;
      9:       return -9'sd49;
      12:      return -9'sd128;
      63:      return 9'sd127;
      default: return 9'(50 - 2 * a);
    endcase
  endfunction

  assign rom_re = rom_re_f(int'(rom_addr));
  assign rom_im = rom_im_f(int'(rom_addr));

  twd1_seq #(.DIN_W(13), .TW_W(9), .FRAME_LEN(512), .ROM_DEPTH(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .rom_addr_out (rom_addr),
    .rom_re_in    (rom_re),
    .rom_im_in    (rom_im),
    .sync_err     (sync_err)
`ifdef TWD1_SEQ_STAT_EN
    ,
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  task automatic drive(input logic v, input logic sof);
    bus.s_valid = v;
    bus.s_sof   = sof;
    bus.s_re    = 13'(sn);
    bus.s_im    = 13'(sn * 5);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.m_ready = 1'b1;
    drive(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b want 0", sync_err); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); end
    checks++; if (bus.m_last !== 1'b0 || bus.m_re !== 13'd0 || bus.m_im !== 13'd0 || bus.m_tw_re !== 9'd0 || bus.m_tw_im !== 9'd0)
      begin errors++; $display("FAIL reset_data: last=%b re=%0d im=%0d tw=(%0d,%0d) want all 0", bus.m_last, bus.m_re, bus.m_im, bus.m_tw_re, bus.m_tw_im); end
    checks++; if (rom_addr !== 9'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
`ifdef TWD1_SEQ_STAT_EN
    checks++; if (frame_cnt !== 16'd0 || err_cnt !== 8'd0 || drop_cnt !== 8'd0)
      begin errors++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", frame_cnt, err_cnt, drop_cnt); end
`endif
  endtask

  task automatic test_frame_start();
    @(posedge clk); #1;
    for (int k = 0; k < 64; k++) begin
      drive(1'b1, k == 0);
      #1;
      checks++; if (rom_addr !== 9'(k)) begin errors++; $display("FAIL start_addr k=%0d: got %0d want %0d", k, rom_addr, k); end
      @(posedge clk); #1;
      checks++; if (bus.m_valid !== 1'b1 || bus.m_re !== 13'(sn) || bus.m_im !== 13'(sn * 5) || bus.m_last !== 1'b0 || sync_err !== 1'b0)
        begin errors++; $display("FAIL start_beat k=%0d: vld=%b re=%0d last=%b err=%b want 1 %0d 0 0", k, bus.m_valid, bus.m_re, bus.m_last, sync_err, 13'(sn)); end
      checks++; if (bus.m_tw_re !== rom_re_f(k) || bus.m_tw_im !== rom_im_f(k))
        begin errors++; $display("FAIL start_tw k=%0d: got (%0d,%0d) want (%0d,%0d)", k, bus.m_tw_re, bus.m_tw_im, rom_re_f(k), rom_im_f(k)); end
      if (k == 9) begin
        checks++; if (bus.m_tw_re !== 9'sd118 || bus.m_tw_im !== -9'sd49) begin errors++; $display("FAIL tw_beat9: got (%0d,%0d) want (118,-49)", bus.m_tw_re, bus.m_tw_im); end
      end
      if (k == 12) begin
        checks++; if (bus.m_tw_re !== 9'sd0 || bus.m_tw_im !== -9'sd128) begin errors++; $display("FAIL tw_beat12: got (%0d,%0d) want (0,-128)", bus.m_tw_re, bus.m_tw_im); end
      end
      if (k == 63) begin
        checks++; if (bus.m_tw_re !== 9'sd13 || bus.m_tw_im !== 9'sd127) begin errors++; $display("FAIL tw_beat63: got (%0d,%0d) want (13,127)", bus.m_tw_re, bus.m_tw_im); end
      end
      sn++;
    end
  endtask

  task automatic test_full_frame();
    for (int k = 64; k < 512; k++) begin
      drive(1'b1, 1'b0);
      #1;
      checks++; if (rom_addr !== 9'(k % 64)) begin errors++; $display("FAIL full_addr k=%0d: got %0d want %0d", k, rom_addr, k % 64); end
      @(posedge clk); #1;
      checks++; if (bus.m_valid !== 1'b1 || bus.m_re !== 13'(sn) || bus.m_last !== (k == 511))
        begin errors++; $display("FAIL full_beat k=%0d: vld=%b re=%0d last=%b want 1 %0d %b", k, bus.m_valid, bus.m_re, bus.m_last, 13'(sn), k == 511); end
      checks++; if (bus.m_tw_re !== rom_re_f(k % 64) || bus.m_tw_im !== rom_im_f(k % 64))
        begin errors++; $display("FAIL full_tw k=%0d: got (%0d,%0d) want (%0d,%0d)", k, bus.m_tw_re, bus.m_tw_im, rom_re_f(k % 64), rom_im_f(k % 64)); end
      if (k == 64 || k == 448) begin
        checks++; if (bus.m_tw_re !== 9'sd128 || bus.m_tw_im !== 9'sd0) begin errors++; $display("FAIL tw_unity k=%0d: got (%0d,%0d) want (128,0)", k, bus.m_tw_re, bus.m_tw_im); end
      end
      sn++;
    end
    drive(1'b1, 1'b0);
    #1;
    checks++; if (rom_addr !== 9'd0 || bus.s_ready !== 1'b1) begin errors++; $display("FAIL drop_addr: addr=%0d rdy=%b want 0 1", rom_addr, bus.s_ready); end
    @(posedge clk); #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL drop_valid: got %b want 0", bus.m_valid); end
`ifdef TWD1_SEQ_STAT_EN
    checks++; if (drop_cnt !== 8'd1 || frame_cnt !== 16'd1) begin errors++; $display("FAIL drop_stats: drop=%0d frame=%0d want 1 1", drop_cnt, frame_cnt); end
`endif
    sn++;
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, k == 0);
      @(posedge clk); #1;
      checks++; if (bus.m_valid !== 1'b1 || bus.m_re !== 13'(sn) || bus.m_tw_re !== rom_re_f(k))
        begin errors++; $display("FAIL bp_pre k=%0d: vld=%b re=%0d tw=%0d want 1 %0d %0d", k, bus.m_valid, bus.m_re, bus.m_tw_re, 13'(sn), rom_re_f(k)); end
      sn++;
    end
    bus.m_ready = 1'b0;
    drive(1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_hs c=%0d: rdy=%b vld=%b want 0 1", c, bus.s_ready, bus.m_valid); end
      checks++; if (bus.m_re !== 13'(sn - 1) || bus.m_im !== 13'((sn - 1) * 5) || bus.m_tw_re !== rom_re_f(9) || bus.m_tw_im !== rom_im_f(9) || bus.m_last !== 1'b0)
        begin errors++; $display("FAIL bp_hold_dat c=%0d: re=%0d tw=(%0d,%0d) want %0d (%0d,%0d)", c, bus.m_re, bus.m_tw_re, bus.m_tw_im, 13'(sn - 1), rom_re_f(9), rom_im_f(9)); end
      checks++; if (rom_addr !== 9'd10) begin errors++; $display("FAIL bp_hold_addr c=%0d: got %0d want 10", c, rom_addr); end
    end
    bus.m_ready = 1'b1;
    #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %b want 1", bus.s_ready); end
    for (int k = 10; k < 20; k++) begin
      drive(1'b1, 1'b0);
      #1;
      checks++; if (rom_addr !== 9'(k)) begin errors++; $display("FAIL bp_addr k=%0d: got %0d want %0d", k, rom_addr, k); end
      @(posedge clk); #1;
      checks++; if (bus.m_valid !== 1'b1 || bus.m_re !== 13'(sn) || bus.m_tw_re !== rom_re_f(k) || bus.m_tw_im !== rom_im_f(k))
        begin errors++; $display("FAIL bp_post k=%0d: vld=%b re=%0d tw=(%0d,%0d) want 1 %0d (%0d,%0d)", k, bus.m_valid, bus.m_re, bus.m_tw_re, bus.m_tw_im, 13'(sn), rom_re_f(k), rom_im_f(k)); end
      sn++;
    end
  endtask

  task automatic test_resync();
    for (int k = 20; k < 100; k++) begin
      drive(1'b1, 1'b0);
      @(posedge clk); #1;
      checks++; if (bus.m_re !== 13'(sn) || bus.m_tw_re !== rom_re_f(k % 64) || sync_err !== 1'b0)
        begin errors++; $display("FAIL rs_pre k=%0d: re=%0d tw=%0d err=%b want %0d %0d 0", k, bus.m_re, bus.m_tw_re, sync_err, 13'(sn), rom_re_f(k % 64)); end
      sn++;
    end
    drive(1'b1, 1'b1);
    #1;
    checks++; if (rom_addr !== 9'd0) begin errors++; $display("FAIL rs_addr: got %0d want 0", rom_addr); end
    @(posedge clk); #1;
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL rs_pulse: got %b want 1", sync_err); end
    checks++; if (bus.m_valid !== 1'b1 || bus.m_re !== 13'(sn) || bus.m_tw_re !== 9'sd128 || bus.m_tw_im !== 9'sd0 || bus.m_last !== 1'b0)
      begin errors++; $display("FAIL rs_beat: vld=%b re=%0d tw=(%0d,%0d) last=%b want 1 %0d (128,0) 0", bus.m_valid, bus.m_re, bus.m_tw_re, bus.m_tw_im, bus.m_last, 13'(sn)); end
`ifdef TWD1_SEQ_STAT_EN
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL rs_err_cnt: got %0d want 1", err_cnt); end
`endif
    sn++;
    for (int j = 1; j < 512; j++) begin
      drive(1'b1, 1'b0);
      #1;
      checks++; if (rom_addr !== 9'(j % 64)) begin errors++; $display("FAIL rs_post_addr j=%0d: got %0d want %0d", j, rom_addr, j % 64); end
      @(posedge clk); #1;
      checks++; if (bus.m_last !== (j == 511) || sync_err !== 1'b0 || bus.m_re !== 13'(sn) || bus.m_tw_im !== rom_im_f(j % 64))
        begin errors++; $display("FAIL rs_post j=%0d: last=%b err=%b re=%0d twi=%0d want %b 0 %0d %0d", j, bus.m_last, sync_err, bus.m_re, bus.m_tw_im, j == 511, 13'(sn), rom_im_f(j % 64)); end
      sn++;
    end
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < 200; k++) begin
      drive(1'b1, k == 0);
      @(posedge clk); #1;
      checks++; if (bus.m_re !== 13'(sn) || bus.m_tw_re !== rom_re_f(k % 64) || sync_err !== 1'b0)
        begin errors++; $display("FAIL rm_pre k=%0d: re=%0d tw=%0d err=%b want %0d %0d 0", k, bus.m_re, bus.m_tw_re, sync_err, 13'(sn), rom_re_f(k % 64)); end
      sn++;
    end
    drive(1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || sync_err !== 1'b0)
      begin errors++; $display("FAIL rm_flush: vld=%b last=%b err=%b want 0 0 0", bus.m_valid, bus.m_last, sync_err); end
    sn++;
    for (int d = 0; d < 3; d++) begin
      drive(1'b1, 1'b0);
      #1;
      checks++; if (rom_addr !== 9'd0) begin errors++; $display("FAIL rm_drop_addr d=%0d: got %0d want 0", d, rom_addr); end
      @(posedge clk); #1;
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rm_drop d=%0d: vld=%b want 0", d, bus.m_valid); end
      sn++;
    end
`ifdef TWD1_SEQ_STAT_EN
    checks++; if (drop_cnt !== 8'd3 || frame_cnt !== 16'd0 || err_cnt !== 8'd0)
      begin errors++; $display("FAIL rm_stats: drop=%0d frame=%0d err=%0d want 3 0 0", drop_cnt, frame_cnt, err_cnt); end
`endif
    drive(1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if (bus.m_valid !== 1'b1 || bus.m_re !== 13'(sn) || bus.m_tw_re !== 9'sd128 || sync_err !== 1'b0)
      begin errors++; $display("FAIL rm_sof: vld=%b re=%0d tw=%0d err=%b want 1 %0d 128 0", bus.m_valid, bus.m_re, bus.m_tw_re, sync_err, 13'(sn)); end
    sn++;
    drive(1'b0, 1'b0);
    @(posedge clk); #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rm_drain: vld=%b want 0", bus.m_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_start();
    test_full_frame();
    test_backpressure();
    test_resync();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
